// File: rtl/counter_display.sv
// Six-digit multiplexed seven-segment driver for mm:ss.hh. The three fields are
// snapshotted once per scan frame and shown on active-low anodes and segments.
module counter_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       disp_en,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic [6:0] ms_10_i,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0] DIGIT_LAST = 3'd5;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [5:0]       snap_min_q, snap_min_d;
  logic [5:0]       snap_sec_q, snap_sec_d;
  logic [6:0]       snap_ms_q, snap_ms_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       wrap;
  logic [7:0] ms_bcd, sec_bcd, min_bcd;
  logic [3:0] cur_val;
  logic       cur_dash;
  logic [5:0] cur_an;
  logic       cur_dp;

  // Tens/ones by threshold compare; the largest multiple of ten not exceeding v wins.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    ones = v[3:0];
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(k * 10)) begin
        tens = 4'(k);
        ones = 4'(v - 7'(k * 10));
      end
    end
    return {tens, ones};
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    wrap      = tick && (digit_q == DIGIT_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    digit_d   = digit_q;
    if (tick) begin
      digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
    end
    snap_min_d = wrap ? min_i   : snap_min_q;
    snap_sec_d = wrap ? sec_i   : snap_sec_q;
    snap_ms_d  = wrap ? ms_10_i : snap_ms_q;
  end

  always_comb begin
    ms_bcd   = bcd_split(snap_ms_q);
    sec_bcd  = bcd_split({1'b0, snap_sec_q});
    min_bcd  = bcd_split({1'b0, snap_min_q});
    cur_val  = ms_bcd[3:0];
    cur_dash = 1'b0;
    cur_an   = 6'b111111;
    cur_dp   = 1'b1;
    case (digit_q)
      3'd0: begin cur_val = ms_bcd[3:0];  cur_dash = (snap_ms_q > 7'd99); cur_an = 6'b111110; end
      3'd1: begin cur_val = ms_bcd[7:4];  cur_dash = (snap_ms_q > 7'd99); cur_an = 6'b111101; end
      3'd2: begin cur_val = sec_bcd[3:0]; cur_an = 6'b111011; cur_dp = 1'b0; end
      3'd3: begin cur_val = sec_bcd[7:4]; cur_an = 6'b110111; end
      3'd4: begin cur_val = min_bcd[3:0]; cur_an = 6'b101111; cur_dp = 1'b0; end
      3'd5: begin cur_val = min_bcd[7:4]; cur_an = 6'b011111; end
      default: begin cur_val = 4'd0; cur_an = 6'b111111; end
    endcase
    // Segments keep tracking while disabled; only anodes and dp are blanked.
    seg_d = cur_dash ? SEG_DASH : seg_lut(cur_val);
    an_d  = disp_en ? cur_an : 6'b111111;
    dp_d  = disp_en ? cur_dp : 1'b1;
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      digit_q    <= 3'd0;
      snap_min_q <= 6'd0;
      snap_sec_q <= 6'd0;
      snap_ms_q  <= 7'd0;
      an_q       <= 6'b111111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      digit_q    <= digit_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      snap_ms_q  <= snap_ms_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/counter_display.md
# counter_display

Six-digit multiplexed seven-segment driver that sits directly downstream of the stopwatch command stage. It consumes the binary minute, second and 10 ms fields and converts each to two decimal digits. It scans them onto a common-anode display with active-low anode and segment lines. Inputs are snapshotted once per scan frame, so a displayed frame never mixes two different time values.

## Interface
- SCAN_DIV, 50000, clock cycles each digit is driven; legal range ≥ 2.
- clk_core  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- disp_en  in  1  1 = display on; 0 = all anodes off while scanning continues.
- min_i  in  6  minutes, binary, 0–63.
- sec_i  in  6  seconds, binary, 0–63.
- ms_10_i  in  7  hundredths, binary, 0–127.
- an  out  6  digit anodes, active-low, one-hot-low when enabled.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- **Divider.** div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt == SCAN_DIV-1).
- **Digit counter.** digit counts 0..5 and advances on tick; 5 wraps to 0.
- **Snapshot.** snap_min, snap_sec and snap_ms load min_i, sec_i and ms_10_i on the edge where tick is high and digit == 5, i.e. the edge at which digit wraps to 0. They hold at all other times.
- **Digit map:**
  - digit 0 = ms ones, an = 111110
  - digit 1 = ms tens, an = 111101
  - digit 2 = sec ones, an = 111011, dp = 0
  - digit 3 = sec tens, an = 110111
  - digit 4 = min ones, an = 101111, dp = 0
  - digit 5 = min tens, an = 011111
  - dp = 1 on all other digits.
- **BCD split.** tens = value/10 and ones = value%10 for values 0–99. Combinational compare/subtract is allowed; no divider IP.
- **Out of range.** Any field > 99 (only ms_10_i can reach this) drives both of its digits as a dash: seg = 0111111.
- **Segment codes, active-low:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- **Output register.** an, seg and dp are registered together from the pre-edge digit and snapshot, so anode and segments always change on the same edge (no ghosting).
- **Display disable.** When disp_en = 0, the registered an = 111111 and dp = 1. seg still updates, and div_cnt, digit and the snapshot continue unaffected. Re-enabling resumes at the current digit; it does not restart the frame.
- **No leading-zero blanking.** Minutes 5 display as "05".

## Timing
- **Reset (asynchronous, takes effect immediately without a clock edge):**
  - div_cnt = 0, digit = 0, snapshot = 0
  - an = 111111, seg = 1111111, dp = 1.
- **First frame after reset release:** the first rising edge drives digit 0 of the all-zero snapshot (an = 111110, seg = 1000000). Live inputs appear only from the first frame wrap, SCAN_DIV·6 cycles after reset release.
- **Output latency:** one cycle after digit changes. Each digit is driven for exactly SCAN_DIV cycles. The frame period is 6·SCAN_DIV cycles.
- **Input capture:** inputs are sampled only on the wrap edge. A change at any other cycle is invisible until the next frame.
- **Simultaneous events:** a wrap edge concurrent with an input change captures the pre-edge input value.
- **Reset mid-frame:** aborts immediately. The scan restarts at digit 0 with the zero snapshot.
- **Enable edge:** a disp_en transition is reflected on an at the next edge.

## Test plan
- **Reset:** assert rst mid-digit 3 with SCAN_DIV = 4 -> an = 111111, seg = 1111111, dp = 1 with no clock edge. After release, first edge gives an = 111110, seg = 1000000.
- **Steady value:** hold min = 12, sec = 34, ms = 56, SCAN_DIV = 4. Second frame shows, each for 4 cycles:
  - 6 (an 111110)
  - 5 (111101)
  - 4 (111011, dp 0)
  - 3 (110111)
  - 2 (101111, dp 0)
  - 1 (011111).
- **Range edges:**
  - ms = 127 -> both ms digits 0111111.
  - min = 63 -> "63".
  - sec = 0 -> "00".
  - ms = 99 -> "99"; ms = 100 -> dashes.
- **Mid-frame change:** change sec 34 -> 35 while digit 1 is active. The rest of the frame still shows 34, the next frame shows 35, and no frame mixes values.
- **Display disable:** drop disp_en for 10 cycles -> an = 111111 and dp = 1 the next edge. The digit sequence is unchanged on re-enable, and the frame period is still 24 cycles.
- **Period:** with SCAN_DIV = 2, each anode is low for exactly 2 cycles and every frame is 12 cycles.
